// File: rtl/ram_pkg.sv
// Shared constants and types for the word-organised data RAM.
// Parameter defaults, index-width helper and the stored-word type live here.
package ram_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_ADDR_WIDTH = 32;
  localparam int DEFAULT_DEPTH      = 64;

  // Number of address bits needed to pick one word out of `depth` words.
  function automatic int idx_width(input int depth);
    return $clog2(depth);
  endfunction

  typedef logic [DEFAULT_DATA_WIDTH-1:0] word_t;

endpackage

// File: rtl/word_ram.sv
// Single-port word RAM: synchronous write, registered read-first read,
// asynchronous active-low clear of both the array and the output register.
module word_ram
  import ram_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int DEPTH      = DEFAULT_DEPTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  write_enable,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out
);

  localparam int IDX_W = idx_width(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] data_out_q;
  logic [DATA_WIDTH-1:0] data_out_d;
  logic [IDX_W-1:0]      idx;
  logic                  unused_addr_bits;

  // Byte lane bits and everything above the word index are dropped, so
  // accesses are word-aligned and wrap modulo DEPTH*4 bytes.
  assign idx              = address[IDX_W+1:2];
  assign unused_addr_bits = ^{address[ADDR_WIDTH-1:IDX_W+2], address[1:0]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (write_enable) begin
      mem_q[idx] <= data_in;
    end
  end

  // Reads the pre-write contents, giving read-first behaviour on collisions.
  always_comb begin
    data_out_d = mem_q[idx];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_out_q <= '0;
    end else begin
      data_out_q <= data_out_d;
    end
  end

  assign data_out = data_out_q;

endmodule

// File: tb/tb_word_ram.sv
// Self-checking bench for word_ram: directed vectors, an array-based
// reference memory checked every falling edge, plus literal expectations.
module tb_word_ram;
  import ram_pkg::*;

  localparam int DEPTH = 64;

  logic        clk;
  logic        reset;
  logic        write_enable;
  logic [31:0] address;
  word_t       data_in;
  word_t       data_out;

  int errors = 0;
  int checks = 0;
  bit check_en = 0;

  word_t model_mem [DEPTH];
  word_t model_out = '0;

  word_ram dut (
    .clk          (clk),
    .reset        (reset),
    .write_enable (write_enable),
    .address      (address),
    .data_in      (data_in),
    .data_out     (data_out)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference memory: word index is the byte address divided by four,
  // taken modulo the number of words; the read sees the old contents.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
      model_out = '0;
    end else begin
      model_out = model_mem[(address / 4) % DEPTH];
      if (write_enable) model_mem[(address / 4) % DEPTH] = data_in;
    end
  end

  task automatic check(input string name, input word_t act, input word_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: DUT output against the reference on every falling edge.
  always @(negedge clk) begin
    if (check_en) check("model_cmp", data_out, model_out);
  end

  // Driver: apply one access, let one rising edge pass, settle 2 ns after it.
  task automatic step(input logic we, input logic [31:0] a, input word_t d);
    write_enable = we;
    address      = a;
    data_in      = d;
    @(posedge clk);
    #2;
  endtask

  initial begin
    reset        = 1'b0;
    write_enable = 1'b1;
    address      = 32'h0;
    data_in      = '0;

    // Reset held with garbage inputs and writes requested.
    for (int i = 0; i < 4; i++) begin
      address = $urandom;
      data_in = $urandom;
      #3;
      check("reset_hold", data_out, 32'h0);
    end

    // Release away from the edge at 15 ns; that edge reads address 4.
    reset        = 1'b1;
    write_enable = 1'b0;
    address      = 32'd4;
    @(posedge clk);
    #2;
    check_en = 1;
    check("post_reset_read", data_out, 32'h0);

    step(1'b1, 32'd4, 32'hA5A5A5A5);
    step(1'b0, 32'd4, 32'h0);
    check("basic_read", data_out, 32'hA5A5A5A5);

    step(1'b1, 32'd8, 32'h11111111);
    step(1'b1, 32'd8, 32'h22222222);
    check("rfw_old", data_out, 32'h11111111);
    step(1'b0, 32'd8, 32'h0);
    check("rfw_new", data_out, 32'h22222222);

    step(1'b1, 32'h0000000E, 32'hDEADBEEF);
    step(1'b0, 32'h0000000C, 32'h0);
    check("alias_low", data_out, 32'hDEADBEEF);
    step(1'b0, 32'h0000010C, 32'h0);
    check("alias_wrap", data_out, 32'hDEADBEEF);
    step(1'b0, 32'hFFFFFF0F, 32'h0);
    check("alias_high", data_out, 32'hDEADBEEF);

    for (int i = 0; i < DEPTH; i++) begin
      step(1'b1, 32'(i) * 32'd4, 32'(i) * 32'h01010101);
    end
    for (int i = DEPTH - 1; i >= 0; i--) begin
      step(1'b0, 32'(i) * 32'd4, 32'h0);
      check("fill_read", data_out, 32'(i) * 32'h01010101);
    end
    check("fill_top_literal", model_mem[63], 32'h3F3F3F3F);

    // Mid-operation reset pulse between edges.
    step(1'b0, 32'd20, 32'h0);
    check("pre_pulse", data_out, 32'h05050505);
    reset = 1'b0;
    #1;
    check("midreset_async", data_out, 32'h0);
    #1;
    reset = 1'b1;
    step(1'b0, 32'd20, 32'h0);
    check("midreset_clear_a", data_out, 32'h0);
    step(1'b0, 32'd252, 32'h0);
    check("midreset_clear_b", data_out, 32'h0);

    // A few more directed accesses after the clear.
    step(1'b1, 32'd36, 32'hCAFEF00D);
    step(1'b0, 32'd36, 32'h0);
    check("post_clear_write", data_out, 32'hCAFEF00D);
    step(1'b0, 32'd40, 32'h0);
    check("post_clear_neighbour", data_out, 32'h0);

    check_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/word_ram.md
Name: word_ram

Overview:
- Single-port, word-organised data RAM for the riscv_zero core's memory subsystem.
- Takes a 32-bit byte address, stores and returns 32-bit words, and has one clock.
- Writes are synchronous; reads are registered with 1-cycle latency.
- Asynchronous active-low reset clears both the output register and the whole array, so every location reads back deterministically.

Parameters:
- DATA_WIDTH, 32: width of a stored word and of data_in / data_out.
- ADDR_WIDTH, 32: width of the byte address port.
- DEPTH, 64: number of words; must be a power of two, at least 2.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous active-low reset (0 = in reset).
- write_enable  input  1  1 = write data_in at address on the next rising clk edge.
- address  input  ADDR_WIDTH  byte address; word index = address[log2(DEPTH)+1:2].
- data_in  input  DATA_WIDTH  write data.
- data_out  output  DATA_WIDTH  registered read data.

Behaviour:
- Reset assertion:
  - reset=0 immediately forces data_out=0 and every memory word to 0, with no clock needed.
  - While reset=0, writes are ignored and the array and data_out stay 0.
  - Deassertion (0->1) takes effect at the next rising clk edge.
- Addressing:
  - address[1:0] is ignored, so accesses are always whole aligned words.
  - Bits above log2(DEPTH)+1 are ignored, so addresses wrap modulo DEPTH*4 bytes.
  - No error or flag is raised for out-of-range addresses.
- Write:
  - On a rising clk edge with reset=1 and write_enable=1, mem[index] <= data_in.
  - Full-word writes only; there are no byte enables.
- Read:
  - On every rising clk edge with reset=1, data_out <= mem[index], whatever write_enable is.
  - Latency: address sampled at edge N gives data on data_out after edge N, stable until edge N+1.
- Read-during-write to the same index (read-first): data_out shows the old contents at that edge. The new value appears one edge later if the address is held.
- data_out holds its value between edges; input changes between edges have no effect.
- No handshake and no busy state: one access per cycle, always accepted.

Decomposition:
- Shared package ram_pkg holds:
  - default constants for DATA_WIDTH, ADDR_WIDTH and DEPTH;
  - a localparam function giving the index width as clog2(DEPTH);
  - a word typedef, logic [DATA_WIDTH-1:0].
- No sub-module: one always block for the array with its asynchronous clear, and one always block for the output register.

Test Plan:
- Reset: hold reset=0 for 10 ns with garbage inputs and write_enable=1 -> data_out=0 throughout; after release, reading address 4 returns 0.
- Basic write/read: release reset, write 0xA5A5A5A5 to address 4 for one edge, then write_enable=0 with address 4 -> data_out=0xA5A5A5A5 after the next edge.
- Read-first collision: location 8 holds 0x11111111; write 0x22222222 to address 8 -> data_out=0x11111111 after that edge, then 0x22222222 one edge later with address held.
- Aliasing: write 0xDEADBEEF to address 0x0000000E; read addresses 0x0C, then 0x100+0x0C (DEPTH=64) -> both return 0xDEADBEEF.
- Fill and verify: write mem[i]=i*0x01010101 for all 64 words, then read them back in reverse order -> every value matches, one cycle latency each.
- Mid-operation reset: after writes, pulse reset=0 between clock edges -> data_out goes to 0 immediately, and a later read of any previously written address returns 0.
